// File: rtl/ir_nec_tx_controller.sv
// ---------------------------------------------------------------------------
// ir_nec_tx_controller
//
// Sequences one NEC-format IR frame. The externally divided carrier
// (~38 kHz) is gated onto the LED output during mark periods.
// The frame consists of a leader mark/space, 32 data bits sent LSB first,
// a stop mark and an optional trailing gap.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   start      in   frame request, only sampled while idle
//   addr[7:0]  in   NEC address, captured on accept
//   cmd[7:0]   in   NEC command, captured on accept
//   carrier_in in   free-running divided carrier (not synchronised here)
//   ir_out     out  gated carrier to the LED driver (inverted if INVERT_OUT)
//   busy       out  frame in progress
//   done       out  one-cycle pulse in the first idle cycle after a frame
// ---------------------------------------------------------------------------
module ir_nec_tx_controller #(
    parameter int UNIT_CYCLES = 56250,
    parameter int CNT_W       = 16,
    parameter int GAP_UNITS   = 0,
    parameter int GAP_W       = 8,
    parameter int INVERT_OUT  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    input  logic       carrier_in,
    output logic       ir_out,
    output logic       busy,
    output logic       done
);

    // The units-remaining counter must hold 16 (leader mark) and GAP_UNITS.
    localparam int UL_W = (GAP_W > 5) ? GAP_W : 5;

    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [UL_W-1:0]  UL_LEAD_MARK  = UL_W'(16);
    localparam logic [UL_W-1:0]  UL_LEAD_SPACE = UL_W'(8);
    localparam logic [UL_W-1:0]  UL_ONE        = UL_W'(1);
    localparam logic [UL_W-1:0]  UL_THREE      = UL_W'(3);
    localparam logic [UL_W-1:0]  UL_GAP        = UL_W'(GAP_UNITS);
    localparam bit               HAS_GAP       = (GAP_UNITS != 0);
    localparam logic             INV_BIT       = (INVERT_OUT != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LEAD_MARK  = 3'd1,
        S_LEAD_SPACE = 3'd2,
        S_BIT_MARK   = 3'd3,
        S_BIT_SPACE  = 3'd4,
        S_STOP_MARK  = 3'd5,
        S_GAP        = 3'd6
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_unit_cnt;
    logic [UL_W-1:0]    r_units_left;
    logic [4:0]         r_bit_idx;
    logic [31:0]        r_frame;
    logic               r_mark;
    logic               r_busy;
    logic               r_done;

    logic               w_unit_end;
    logic               w_state_end;
    logic               w_bit;

    assign w_unit_end  = (r_unit_cnt == CNT_LAST);
    // A state ends on the last cycle of its last remaining unit.
    assign w_state_end = w_unit_end && (r_units_left == UL_ONE);
    assign w_bit       = r_frame[r_bit_idx];

    // Frame sequencer: state, unit timing, bit index and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_unit_cnt   <= '0;
            r_units_left <= '0;
            r_bit_idx    <= 5'd0;
            r_frame      <= 32'd0;
            r_mark       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Common unit timing; transitions below overwrite units_left.
            if (r_state != S_IDLE) begin
                if (w_unit_end) begin
                    r_unit_cnt   <= '0;
                    r_units_left <= r_units_left - UL_ONE;
                end else begin
                    r_unit_cnt <= r_unit_cnt + CNT_ONE;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_frame      <= {~cmd, cmd, ~addr, addr};
                        r_state      <= S_LEAD_MARK;
                        r_unit_cnt   <= '0;
                        r_units_left <= UL_LEAD_MARK;
                        r_bit_idx    <= 5'd0;
                        r_mark       <= 1'b1;
                        r_busy       <= 1'b1;
                    end else begin
                        r_mark <= 1'b0;
                        r_busy <= 1'b0;
                    end
                end
                S_LEAD_MARK: begin
                    if (w_state_end) begin
                        r_state      <= S_LEAD_SPACE;
                        r_units_left <= UL_LEAD_SPACE;
                        r_mark       <= 1'b0;
                    end
                end
                S_LEAD_SPACE: begin
                    if (w_state_end) begin
                        r_state      <= S_BIT_MARK;
                        r_units_left <= UL_ONE;
                        r_mark       <= 1'b1;
                    end
                end
                S_BIT_MARK: begin
                    if (w_state_end) begin
                        r_state      <= S_BIT_SPACE;
                        // Logical one is encoded as a long (3-unit) space.
                        r_units_left <= w_bit ? UL_THREE : UL_ONE;
                        r_mark       <= 1'b0;
                    end
                end
                S_BIT_SPACE: begin
                    if (w_state_end) begin
                        r_units_left <= UL_ONE;
                        r_mark       <= 1'b1;
                        if (r_bit_idx == 5'd31) begin
                            r_state <= S_STOP_MARK;
                        end else begin
                            r_state   <= S_BIT_MARK;
                            r_bit_idx <= r_bit_idx + 5'd1;
                        end
                    end
                end
                S_STOP_MARK: begin
                    if (w_state_end) begin
                        r_mark <= 1'b0;
                        if (HAS_GAP) begin
                            r_state      <= S_GAP;
                            r_units_left <= UL_GAP;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (w_state_end) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_mark  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // The carrier path is deliberately a plain gate: no register delay.
    assign ir_out = (r_mark & carrier_in) ^ INV_BIT;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_ir_nec_tx_controller.sv
// ---------------------------------------------------------------------------
// tb_ir_nec_tx_controller
//
// Two instances: dut0 (no gap, normal polarity) and dut1 (2-unit gap,
// inverted output). Stimulus pushes expected frames into a per-DUT queue;
// a negedge monitor pops a record whenever busy rises and compares every
// cycle of the waveform against a timeline model, then checks frame length,
// done pulse and the decoded data word at the end of the frame.
// ---------------------------------------------------------------------------
module tb_ir_nec_tx_controller;

    localparam int U = 4;

    typedef struct {
        logic [31:0] word;
        int          abort_at;
        bit          b2b;
    } exp_t;

    logic       clk = 1'b0;
    logic [1:0] reset_s;
    logic [1:0] start_s;
    logic [7:0] addr_s [2];
    logic [7:0] cmd_s  [2];
    logic       carrier;
    bit         car_tog;
    bit         mon_en;
    wire  [1:0] ir_w;
    wire  [1:0] busy_w;
    wire  [1:0] done_w;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    bit          in_frame [2];
    int          k_cnt    [2];
    int          idle_cnt [2];
    exp_t        cur      [2];
    bit          dec_ok   [2];
    int          sp_len   [2];
    int          nsp      [2];
    int          nbit     [2];
    logic [31:0] dec_w    [2];

    ir_nec_tx_controller #(.UNIT_CYCLES(U), .CNT_W(16), .GAP_UNITS(0),
                           .GAP_W(8), .INVERT_OUT(0)) dut0 (
        .clk(clk), .reset(reset_s[0]), .start(start_s[0]),
        .addr(addr_s[0]), .cmd(cmd_s[0]), .carrier_in(carrier),
        .ir_out(ir_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    ir_nec_tx_controller #(.UNIT_CYCLES(U), .CNT_W(16), .GAP_UNITS(2),
                           .GAP_W(8), .INVERT_OUT(1)) dut1 (
        .clk(clk), .reset(reset_s[1]), .start(start_s[1]),
        .addr(addr_s[1]), .cmd(cmd_s[1]), .carrier_in(carrier),
        .ir_out(ir_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    always #5 clk = ~clk;

    // Carrier: constant 1 (decodable) or toggling every 3 cycles.
    initial begin
        int cc;
        cc = 0;
        carrier = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (car_tog) begin
                cc = cc + 1;
                if (cc == 3) begin
                    carrier = ~carrier;
                    cc = 0;
                end
            end else begin
                carrier = 1'b1;
                cc = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Expected mark level k cycles into a frame, from the NEC timeline.
    function automatic bit mark_at(input logic [31:0] w, input int k);
        int t;
        int sp;
        if (k < 16 * U) return 1'b1;
        if (k < 24 * U) return 1'b0;
        t = 24 * U;
        for (int i = 0; i < 32; i++) begin
            if (k < t + U) return 1'b1;
            t = t + U;
            sp = w[i] ? 3 * U : U;
            if (k < t + sp) return 1'b0;
            t = t + sp;
        end
        if (k < t + U) return 1'b1;
        return 1'b0;
    endfunction

    task automatic mon_step(input int id, input logic b, input logic ir, input logic dn);
        logic inv;
        int   gap;
        int   len;
        logic m;
        bit   have;
        inv = (id == 1);
        gap = (id == 1) ? 2 : 0;
        if (in_frame[id] && !b) begin
            len = (cur[id].abort_at >= 0) ? cur[id].abort_at + 1 : (121 + gap) * U;
            chk("frame_len", k_cnt[id], len);
            chk("done_pulse", {31'd0, dn}, {31'd0, cur[id].abort_at < 0});
            if (cur[id].abort_at < 0 && dec_ok[id]) begin
                chk("decode_bits", nbit[id], 32);
                chk("decode_word", dec_w[id], cur[id].word);
            end
            chk("idle_out", {31'd0, ir}, {31'd0, inv});
            in_frame[id] = 1'b0;
            idle_cnt[id] = 1;
        end else if (!b) begin
            chk("done_idle", {31'd0, dn}, 32'd0);
            chk("idle_out", {31'd0, ir}, {31'd0, inv});
            idle_cnt[id]++;
        end else begin
            if (!in_frame[id]) begin
                have = (id == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
                chk("frame_expected", {31'd0, have}, 32'd1);
                if (have) cur[id] = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                else begin
                    cur[id].word = 32'd0;
                    cur[id].abort_at = -1;
                    cur[id].b2b = 1'b0;
                end
                if (cur[id].b2b) chk("b2b_gap", idle_cnt[id], 1);
                in_frame[id] = 1'b1;
                k_cnt[id]    = 0;
                dec_ok[id]   = !car_tog;
                sp_len[id]   = 0;
                nsp[id]      = 0;
                nbit[id]     = 0;
                dec_w[id]    = 32'd0;
            end
            m = mark_at(cur[id].word, k_cnt[id]);
            chk("ir_out", {31'd0, ir}, {31'd0, (m & carrier) ^ inv});
            chk("done_busy", {31'd0, dn}, 32'd0);
            // Pulse-distance decode from the observed output.
            if ((ir ^ inv) == 1'b0) begin
                sp_len[id]++;
            end else if (sp_len[id] > 0) begin
                if (nsp[id] > 0 && nbit[id] < 32) begin
                    dec_w[id][nbit[id]] = (sp_len[id] > 2 * U);
                    nbit[id]++;
                end
                nsp[id]++;
                sp_len[id] = 0;
            end
            k_cnt[id]++;
        end
    endtask

    // Monitor: samples both DUTs on the inactive clock edge.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_step(0, busy_w[0], ir_w[0], done_w[0]);
            mon_step(1, busy_w[1], ir_w[1], done_w[1]);
        end
    end

    task automatic push_exp(input int id, input logic [7:0] a, input logic [7:0] c,
                            input int abort_at, input bit b2b);
        exp_t e;
        e.word = {~c, c, ~a, a};
        e.abort_at = abort_at;
        e.b2b = b2b;
        if (id == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    task automatic send(input int id, input logic [7:0] a, input logic [7:0] c, input int abort_at);
        push_exp(id, a, c, abort_at, 1'b0);
        @(posedge clk);
        #1;
        addr_s[id]  = a;
        cmd_s[id]   = c;
        start_s[id] = 1'b1;
        @(posedge clk);
        #1;
        start_s[id] = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_w[id] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, busy_w[id]}, 32'd0);
    endtask

    task automatic wait_busy(input int id);
        int n;
        n = 0;
        @(negedge clk);
        while (!busy_w[id] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("busy_timeout", {31'd0, busy_w[id]}, 32'd1);
    endtask

    task automatic run_dut(input int id);
        logic [7:0] a;
        logic [7:0] c;
        // Basic frame, constant carrier (also decoded).
        send(id, 8'h01, 8'h00, -1);
        wait_idle(id);
        // Same frame with toggling carrier.
        car_tog = 1'b1;
        send(id, 8'h01, 8'h00, -1);
        wait_idle(id);
        car_tog = 1'b0;
        // Decode frame.
        send(id, 8'hA5, 8'h3C, -1);
        wait_idle(id);
        // Start while busy must be ignored.
        send(id, 8'h12, 8'h34, -1);
        repeat (100) @(posedge clk);
        #1;
        addr_s[id]  = 8'hFF;
        start_s[id] = 1'b1;
        @(posedge clk);
        #1;
        start_s[id] = 1'b0;
        wait_idle(id);
        repeat (5) @(posedge clk);
        // Back-to-back with start held; addr/cmd change mid-frame.
        push_exp(id, 8'h5A, 8'h81, -1, 1'b0);
        push_exp(id, 8'hC7, 8'h2E, -1, 1'b1);
        @(posedge clk);
        #1;
        addr_s[id]  = 8'h5A;
        cmd_s[id]   = 8'h81;
        start_s[id] = 1'b1;
        @(posedge clk);
        repeat (300) @(posedge clk);
        #1;
        addr_s[id] = 8'hC7;
        cmd_s[id]  = 8'h2E;
        wait_idle(id);
        wait_busy(id);
        @(posedge clk);
        #1;
        start_s[id] = 1'b0;
        wait_idle(id);
        // Reset mid-frame at busy cycle 200, then a fresh frame.
        send(id, 8'h3C, 8'hA5, 200);
        repeat (200) @(posedge clk);
        #1;
        reset_s[id] = 1'b1;
        @(posedge clk);
        #1;
        reset_s[id] = 1'b0;
        @(posedge clk);
        send(id, 8'h69, 8'h96, -1);
        wait_idle(id);
        // Randomised frames.
        for (int r = 0; r < 5; r++) begin
            a = 8'($urandom);
            c = 8'($urandom);
            car_tog = ($urandom_range(0, 1) == 1);
            send(id, a, c, -1);
            wait_idle(id);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            car_tog = 1'b0;
        end
        repeat (4) @(posedge clk);
    endtask

    initial begin
        reset_s   = 2'b11;
        start_s   = 2'b00;
        addr_s[0] = 8'h00;
        addr_s[1] = 8'h00;
        cmd_s[0]  = 8'h00;
        cmd_s[1]  = 8'h00;
        car_tog   = 1'b0;
        mon_en    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_frame[i] = 1'b0;
            idle_cnt[i] = 100;
        end
        repeat (3) @(posedge clk);
        #1;
        reset_s = 2'b00;
        @(negedge clk);
        chk("rst_busy", {30'd0, busy_w}, 32'd0);
        chk("rst_done", {30'd0, done_w}, 32'd0);
        chk("rst_ir_out", {30'd0, ir_w}, 32'd2);
        mon_en = 1'b1;
        run_dut(0);
        run_dut(1);
        chk("exp_q0_empty", exp_q0.size(), 0);
        chk("exp_q1_empty", exp_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ir_nec_tx_controller.md
Name: ir_nec_tx_controller

Overview:
- Sequences one NEC-format IR frame by gating the externally divided carrier (~38 kHz from the clock divider) onto the IR LED output.
- Accepts an 8-bit address and 8-bit command on a start handshake.
- Emits leader, 32 data bits, stop mark and an optional trailing gap.
- Sits between the user/control logic and the IR LED driver pin.

Parameters:
- UNIT_CYCLES, 56250: clk cycles per NEC time unit (562.5 us at 100 MHz); must be >= 2.
- CNT_W, 16: width of the intra-unit cycle counter; must hold UNIT_CYCLES-1.
- GAP_UNITS, 0: trailing space units after the stop mark; busy stays high during the gap; 0 = no gap state.
- GAP_W, 8: width of the gap unit counter; must hold GAP_UNITS.
- INVERT_OUT, 0: 1 = ir_out is active-low (idle high, mark = ~carrier_in).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  frame request; sampled only in IDLE.
- addr  input  8  NEC address; captured on accept.
- cmd  input  8  NEC command; captured on accept.
- carrier_in  input  1  divided carrier from the clock divider; free-running, not synchronised by this block.
- ir_out  output  1  gated carrier to the LED driver.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (synchronous, checked first each edge):
  - state=IDLE; all counters 0; mark=0; busy=0; done=0.
  - ir_out = 0 (or 1 if INVERT_OUT) combinationally once mark=0.
  - Reset mid-frame aborts the frame next edge, with no done pulse.
- ir_out = mark ? carrier_in : 0, XOR INVERT_OUT. mark, busy and done are registered; the carrier path is a combinational AND only.
- Frame word: F[31:0] = {~cmd, cmd, ~addr, addr}, captured at accept, sent bit 0 first.
- States and durations (U = UNIT_CYCLES clk cycles):
  - IDLE.
  - LEAD_MARK: 16U, mark=1.
  - LEAD_SPACE: 8U.
  - BIT_MARK: 1U, mark=1.
  - BIT_SPACE: 1U if F[i]=0, 3U if F[i]=1.
  - STOP_MARK: 1U, mark=1.
  - GAP: GAP_UNITS U; skipped when GAP_UNITS=0.
- Transitions:
  - BIT_SPACE returns to BIT_MARK for i<31 and goes to STOP_MARK after i=31.
  - STOP_MARK goes to GAP, or to IDLE when there is no gap.
  - GAP goes to IDLE.
- Accept: state=IDLE and start=1 at an edge. Next cycle: state=LEAD_MARK, busy=1, mark=1.
- Timing:
  - Each state lasts exactly its unit count × UNIT_CYCLES cycles, counted by unit_cnt wrapping at UNIT_CYCLES-1 plus a units-remaining counter.
  - There are no idle cycles between states.
- Frame length is data-independent: busy is high for exactly (121+GAP_UNITS)×UNIT_CYCLES cycles. The data always contains 16 ones and 16 zeros: 24U leader + 96U data + 1U stop.
- done is high in the first IDLE cycle after the frame (busy=0 that cycle) and is a one-cycle pulse.
- start while busy is ignored, with no queuing; addr/cmd changes while busy have no effect.
- start held high in the done cycle is accepted; the back-to-back frame begins the next cycle.
- carrier_in phase is not aligned to mark edges; partial carrier cycles at mark boundaries are acceptable.

Test Plan:
- UNIT_CYCLES=4, GAP_UNITS=0, addr=0x01, cmd=0x00, 1-cycle start pulse:
  - busy high for exactly 484 cycles.
  - mark high cycles 0-63 (cycle 0 = first busy cycle); BIT_MARK windows at cycles 96-99 and 112-115.
  - stop mark at cycles 480-483; done=1 at cycle 484 only.
- Same frame with carrier_in toggling every 3 cycles: ir_out equals carrier_in in every mark cycle and is 0 in every space and idle cycle. With INVERT_OUT=1, ir_out is exactly the complement.
- Decode check: a bench decoder measures the space lengths of 32 bits for addr=0xA5, cmd=0x3C. It must recover 0xC33C5AA5 (LSB first), and the frame length is again 484 cycles.
- Busy-ignore: a second start with addr=0xFF asserted at busy cycle 100 has no effect on the waveform; busy falls at 484; no second frame starts.
- Back-to-back: start held high continuously gives done at cycle 484 and a new LEAD_MARK at cycle 485. With GAP_UNITS=2, done moves to cycle 492.
- Reset at busy cycle 200: next cycle busy=0, ir_out=0, done never pulses. A start 2 cycles later launches a full 484-cycle frame.
